// File: rtl/vec_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vec_ctrl_pkg
// Shared definitions for the Vec_CPU pipeline control slice:
//   - mem_op_e    : memory-operation encoding carried by the *_cl_mem_op fields
//   - hz_state_e  : hazard-controller FSM states
//   - REG_AW_DEF  : default register-address width (scalar and vector files)
//   - is_mem_access() : true for operations that actually touch memory
// -----------------------------------------------------------------------------
package vec_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_RSVD  = 2'd3
    } mem_op_e;

    typedef enum logic [0:0] {
        HZ_RUN  = 1'b0,
        HZ_VMEM = 1'b1
    } hz_state_e;

    // The reserved encoding behaves exactly like "no memory operation".
    function automatic logic is_mem_access(input logic [1:0] op);
        logic hit;
        case (op)
            MEM_LOAD, MEM_STORE: hit = 1'b1;
            MEM_NONE, MEM_RSVD:  hit = 1'b0;
            default:             hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/hz_detect.sv
// -----------------------------------------------------------------------------
// hz_detect
// Purely combinational load-use hazard detector between ID and EX. Kept as a
// separate block so a future forwarding unit can reuse the same match logic.
// Ports:
//   id_src1, id_src2 : ID-stage source registers
//   id_vec_src       : 1 = ID sources name vector registers, 0 = scalar
//   ex_cl_mem_op     : EX-stage memory op (mem_op_e encoding)
//   ex_cl_esc_wr     : EX-stage scalar write control (non-zero = writes)
//   ex_cl_vec_wr     : EX-stage vector write control (non-zero = writes)
//   ex_rd            : EX-stage destination register
//   lu               : load-use hazard present this cycle
// -----------------------------------------------------------------------------
module hz_detect
    import vec_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_vec_src,
    input  logic [1:0]        ex_cl_mem_op,
    input  logic [1:0]        ex_cl_esc_wr,
    input  logic [1:0]        ex_cl_vec_wr,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              lu
);

    logic is_load_s;
    logic src_match_s;
    logic wr_active_s;

    // Hazard only when the EX load writes the same register class ID reads.
    always_comb begin
        is_load_s   = (ex_cl_mem_op == MEM_LOAD);
        src_match_s = (ex_rd == id_src1) || (ex_rd == id_src2);
        if (id_vec_src) begin
            wr_active_s = (ex_cl_vec_wr != 2'd0);
        end else begin
            wr_active_s = (ex_cl_esc_wr != 2'd0);
        end
        lu = is_load_s && src_match_s && wr_active_s;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Generates per-stage enables and flushes for the Vec_CPU pipeline registers
// (IF/ID, ID/EX, EX/MEM, MEM/WB). Inserts one bubble on a load-use hazard and
// freezes the whole pipeline while a multi-cycle vector memory op sits in MEM.
// A saturating counter records stalled cycles (en_if low) for debug.
// Ports:
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   id_src1/2, id_vec_src: ID-stage source operands and their register class
//   ex_cl_mem_op, ex_cl_esc_wr, ex_cl_vec_wr, ex_rd : EX-stage controls
//   mem_cl_mem_op, mem_vec_op : MEM-stage op and vector flag
//   en_if/en_id/en_ex/en_mem  : pipeline register enables
//   flush_ex, flush_wb        : bubble-load controls (override enables)
//   busy                      : vector-memory occupancy in progress
//   stall_cnt                 : saturating stalled-cycle counter
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import vec_ctrl_pkg::*;
#(
    parameter int REG_AW         = REG_AW_DEF,
    parameter int VEC_MEM_CYCLES = 4,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_AW-1:0]      id_src1,
    input  logic [REG_AW-1:0]      id_src2,
    input  logic                   id_vec_src,
    input  logic [1:0]             ex_cl_mem_op,
    input  logic [1:0]             ex_cl_esc_wr,
    input  logic [1:0]             ex_cl_vec_wr,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic [1:0]             mem_cl_mem_op,
    input  logic                   mem_vec_op,
    output logic                   en_if,
    output logic                   en_id,
    output logic                   en_ex,
    output logic                   en_mem,
    output logic                   flush_ex,
    output logic                   flush_wb,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int CNT_W    = $clog2(VEC_MEM_CYCLES) + 1;
    // The trigger cycle and the exit cycle are not counted by cnt, hence -2.
    localparam int CNT_INIT = (VEC_MEM_CYCLES > 1) ? (VEC_MEM_CYCLES - 2) : 0;
    localparam logic [CNT_W-1:0]       CNT_LOAD   = CNT_W'(CNT_INIT);
    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
    localparam logic                   VM_ENABLED = (VEC_MEM_CYCLES > 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX  = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE  = STALL_CNT_W'(1);

    localparam logic [0:0] ST_RUN  = 1'(HZ_RUN);
    localparam logic [0:0] ST_VMEM = 1'(HZ_VMEM);

    logic [0:0]             state_r;
    logic [0:0]             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   lu_s;
    logic                   vm_s;
    logic                   freeze_s;

    hz_detect #(
        .REG_AW (REG_AW)
    ) u_hz_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_vec_src   (id_vec_src),
        .ex_cl_mem_op (ex_cl_mem_op),
        .ex_cl_esc_wr (ex_cl_esc_wr),
        .ex_cl_vec_wr (ex_cl_vec_wr),
        .ex_rd        (ex_rd),
        .lu           (lu_s)
    );

    // Vector-memory trigger and freeze condition; vm is masked in VMEM so the
    // op already being serviced cannot restart its own freeze.
    always_comb begin
        vm_s     = is_mem_access(mem_cl_mem_op) && mem_vec_op && VM_ENABLED
                   && (state_r == ST_RUN);
        freeze_s = vm_s || ((state_r == ST_VMEM) && (cnt_r != '0));
    end

    // FSM next state and occupancy countdown.
    always_comb begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = '0;
        case (state_r)
            ST_RUN: begin
                if (vm_s) begin
                    state_nxt_s = ST_VMEM;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                end
            end
            ST_VMEM: begin
                if (cnt_r != '0) begin
                    state_nxt_s = ST_VMEM;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // FSM state and countdown registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Stage controls; reset dominates, then freeze, then the load-use bubble.
    // During a freeze EX/MEM holds (no flush) while WB takes bubbles.
    always_comb begin
        if (rst) begin
            en_if    = 1'b0;
            en_id    = 1'b0;
            en_ex    = 1'b0;
            en_mem   = 1'b0;
            flush_ex = 1'b1;
            flush_wb = 1'b1;
            busy     = 1'b0;
        end else if (freeze_s) begin
            en_if    = 1'b0;
            en_id    = 1'b0;
            en_ex    = 1'b0;
            en_mem   = 1'b0;
            flush_ex = 1'b0;
            flush_wb = 1'b1;
            busy     = 1'b1;
        end else if (lu_s) begin
            en_if    = 1'b0;
            en_id    = 1'b0;
            en_ex    = 1'b1;
            en_mem   = 1'b1;
            flush_ex = 1'b1;
            flush_wb = 1'b0;
            busy     = (state_r == ST_VMEM);
        end else begin
            en_if    = 1'b1;
            en_id    = 1'b1;
            en_ex    = 1'b1;
            en_mem   = 1'b1;
            flush_ex = 1'b0;
            flush_wb = 1'b0;
            busy     = (state_r == ST_VMEM);
        end
    end

    // Saturating stalled-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (!en_if && (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_r <= stall_cnt_r + STALL_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Two DUT instances share the same stimulus: dut0 with defaults
// (VEC_MEM_CYCLES=4, 16-bit counter) and dut1 with VEC_MEM_CYCLES=2 and a
// 2-bit counter to exercise the shortest freeze and counter saturation.
// The reference model tracks "MEM occupancy cycles still to go" per instance.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_src1, id_src2, ex_rd;
    logic       id_vec_src, mem_vec_op;
    logic [1:0] ex_cl_mem_op, ex_cl_esc_wr, ex_cl_vec_wr, mem_cl_mem_op;

    logic        en_if0, en_id0, en_ex0, en_mem0, flush_ex0, flush_wb0, busy0;
    logic        en_if1, en_id1, en_ex1, en_mem1, flush_ex1, flush_wb1, busy1;
    logic [15:0] stall0;
    logic [1:0]  stall1;
    logic [6:0]  out0, out1;

    int n_tests = 0;
    int n_fail  = 0;
    int occ[2];
    int scnt[2];
    int vmc[2]  = '{4, 2};
    int smax[2] = '{65535, 3};

    always #5 clk = ~clk;

    assign out0 = {en_if0, en_id0, en_ex0, en_mem0, flush_ex0, flush_wb0, busy0};
    assign out1 = {en_if1, en_id1, en_ex1, en_mem1, flush_ex1, flush_wb1, busy1};

    pipe_hazard_ctrl dut0 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_vec_src(id_vec_src), .ex_cl_mem_op(ex_cl_mem_op),
        .ex_cl_esc_wr(ex_cl_esc_wr), .ex_cl_vec_wr(ex_cl_vec_wr), .ex_rd(ex_rd),
        .mem_cl_mem_op(mem_cl_mem_op), .mem_vec_op(mem_vec_op),
        .en_if(en_if0), .en_id(en_id0), .en_ex(en_ex0), .en_mem(en_mem0),
        .flush_ex(flush_ex0), .flush_wb(flush_wb0), .busy(busy0), .stall_cnt(stall0)
    );

    pipe_hazard_ctrl #(.VEC_MEM_CYCLES(2), .STALL_CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_vec_src(id_vec_src), .ex_cl_mem_op(ex_cl_mem_op),
        .ex_cl_esc_wr(ex_cl_esc_wr), .ex_cl_vec_wr(ex_cl_vec_wr), .ex_rd(ex_rd),
        .mem_cl_mem_op(mem_cl_mem_op), .mem_vec_op(mem_vec_op),
        .en_if(en_if1), .en_id(en_id1), .en_ex(en_ex1), .en_mem(en_mem1),
        .flush_ex(flush_ex1), .flush_wb(flush_wb1), .busy(busy1), .stall_cnt(stall1)
    );

    task automatic set_idle();
        id_src1 = 5'd0; id_src2 = 5'd0; id_vec_src = 1'b0; ex_rd = 5'd31;
        ex_cl_mem_op = 2'd0; ex_cl_esc_wr = 2'd0; ex_cl_vec_wr = 2'd0;
        mem_cl_mem_op = 2'd0; mem_vec_op = 1'b0;
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic step(input string tag);
        logic       lu_m, vacc_m, bz;
        logic [6:0] exp_v, obs_v;
        logic [31:0] obs_c;
        int nocc[2];
        int nscnt[2];
        #1;
        lu_m = (ex_cl_mem_op == 2'd1) && ((ex_rd == id_src1) || (ex_rd == id_src2))
               && (id_vec_src ? (ex_cl_vec_wr != 2'd0) : (ex_cl_esc_wr != 2'd0));
        vacc_m = ((mem_cl_mem_op == 2'd1) || (mem_cl_mem_op == 2'd2)) && mem_vec_op;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                occ[d]  = 0;
                scnt[d] = 0;
                exp_v   = 7'b0000110;
                nocc[d] = 0;
            end else if ((occ[d] == 0) && vacc_m && (vmc[d] > 1)) begin
                exp_v   = 7'b0000011;
                nocc[d] = vmc[d] - 1;
            end else if (occ[d] > 1) begin
                exp_v   = 7'b0000011;
                nocc[d] = occ[d] - 1;
            end else begin
                bz      = (occ[d] == 1);
                exp_v   = lu_m ? {4'b0011, 1'b1, 1'b0, bz} : {4'b1111, 2'b00, bz};
                nocc[d] = 0;
            end
            obs_v = (d == 0) ? out0 : out1;
            obs_c = (d == 0) ? 32'(stall0) : 32'(stall1);
            n_tests++;
            assert (obs_v === exp_v) else begin
                n_fail++;
                $error("FAIL %s dut%0d ctrl observed=%b expected=%b", tag, d, obs_v, exp_v);
            end
            n_tests++;
            assert (obs_c === 32'(scnt[d])) else begin
                n_fail++;
                $error("FAIL %s dut%0d stall_cnt observed=%0d expected=%0d", tag, d, obs_c, scnt[d]);
            end
            nscnt[d] = (!exp_v[6] && !rst && (scnt[d] < smax[d])) ? scnt[d] + 1 : scnt[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            occ[d]  = rst ? 0 : nocc[d];
            scnt[d] = rst ? 0 : nscnt[d];
        end
        #1;
    endtask

    initial begin
        occ  = '{0, 0};
        scnt = '{0, 0};
        rst  = 1'b1;
        set_idle();
        step("reset0");
        step("reset1");
        rst = 1'b0;
        step("idle");

        // Scalar load-use: one bubble, then free-running.
        ex_cl_mem_op = 2'd1; ex_rd = 5'd3; ex_cl_esc_wr = 2'd1; id_src1 = 5'd3;
        step("lu_scalar");
        set_idle();
        step("lu_after");

        // Same register but vector sources while EX writes only scalar.
        ex_cl_mem_op = 2'd1; ex_rd = 5'd3; ex_cl_esc_wr = 2'd1; id_src1 = 5'd3;
        id_vec_src = 1'b1; ex_cl_vec_wr = 2'd0;
        step("class_mismatch");
        ex_cl_vec_wr = 2'd2;
        step("lu_vector");
        set_idle();
        step("idle2");

        // Vector store occupies MEM for four cycles.
        mem_cl_mem_op = 2'd2; mem_vec_op = 1'b1;
        for (int i = 0; i < 4; i++) step("vfreeze");
        set_idle();
        step("vfreeze_done");
        step("vfreeze_idle");

        // Reserved op and scalar memory op must not freeze.
        mem_cl_mem_op = 2'd3; mem_vec_op = 1'b1;
        step("rsvd_no_freeze");
        mem_cl_mem_op = 2'd1; mem_vec_op = 1'b0;
        step("scalar_mem");
        set_idle();

        // Freeze and load-use together; load-use surfaces at the exit cycle.
        mem_cl_mem_op = 2'd1; mem_vec_op = 1'b1;
        ex_cl_mem_op = 2'd1; ex_rd = 5'd7; id_src2 = 5'd7; ex_cl_esc_wr = 2'd3;
        for (int i = 0; i < 4; i++) step("vm_plus_lu");
        set_idle();
        step("vm_lu_done");

        // Reset in the middle of a freeze.
        mem_cl_mem_op = 2'd2; mem_vec_op = 1'b1;
        step("rst_mid_trig");
        step("rst_mid_vmem");
        rst = 1'b1;
        step("rst_mid_assert");
        set_idle();
        rst = 1'b0;
        step("rst_mid_release");
        step("rst_mid_idle");

        // Five consecutive load-use cycles saturate the 2-bit counter.
        ex_cl_mem_op = 2'd1; ex_rd = 5'd9; id_src1 = 5'd9; ex_cl_esc_wr = 2'd1;
        for (int i = 0; i < 5; i++) step("saturate");
        set_idle();
        step("sat_hold");

        // Randomized traffic on a small register range to hit matches often.
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 63) == 0);
            id_src1       = 5'($urandom_range(0, 3));
            id_src2       = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            id_vec_src    = 1'($urandom_range(0, 1));
            ex_cl_mem_op  = 2'($urandom_range(0, 3));
            ex_cl_esc_wr  = 2'($urandom_range(0, 3));
            ex_cl_vec_wr  = 2'($urandom_range(0, 3));
            mem_cl_mem_op = 2'($urandom_range(0, 3));
            mem_vec_op    = ($urandom_range(0, 3) == 0);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
